// File: rtl/duty_phase_loader.sv
// duty_phase_loader: feeds the silent LPF stage.
// On each START it streams TRANS_NUM duty/phase words from the operation BRAM.
// It scales each duty by (MOD+1)/2^WIDTH and collects the results in a shadow
// buffer. The shadow buffer is copied to the front DUTY/PHASE arrays with a
// one-cycle UPDATE pulse once the downstream stage reports DOWN_READY.
module duty_phase_loader #(
  parameter int TRANS_NUM    = 249,
  parameter int WIDTH        = 8,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_WIDTH   = $clog2(TRANS_NUM)
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            START,
  input  logic [WIDTH-1:0]                MOD,
  input  logic                            DOWN_READY,
  output logic                            BRAM_EN,
  output logic [ADDR_WIDTH-1:0]           BRAM_ADDR,
  input  logic [2*WIDTH-1:0]              BRAM_DATA,
  output logic [TRANS_NUM-1:0][WIDTH-1:0] DUTY,
  output logic [TRANS_NUM-1:0][WIDTH-1:0] PHASE,
  output logic                            UPDATE,
  output logic                            BUSY,
  output logic                            OVERRUN
);

  // The capture counter must be able to reach TRANS_NUM itself.
  localparam int CNT_WIDTH = $clog2(TRANS_NUM + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT_READY} state_t;

  state_t                            state_q, state_d;
  logic [WIDTH-1:0]                  mod_q;
  logic [ADDR_WIDTH-1:0]             rd_cnt;
  logic [CNT_WIDTH-1:0]              wr_cnt;
  logic [ADDR_WIDTH-1:0]             wr_idx;
  logic [READ_LATENCY-1:0]           rd_pipe;
  logic [WIDTH-1:0]                  s1_duty;
  logic [WIDTH-1:0]                  s1_phase;
  logic [TRANS_NUM-1:0][WIDTH-1:0]   shadow_duty;
  logic [TRANS_NUM-1:0][WIDTH-1:0]   shadow_phase;
  logic [WIDTH-1:0]                  raw_duty;
  logic [WIDTH-1:0]                  raw_phase;
  logic [WIDTH:0]                    mod_p1;
  logic [2*WIDTH-1:0]                product;
  logic                              accept;
  logic                              last_rd;
  logic                              s2_wr;
  logic                              last_wr;
  logic                              do_update;

  assign accept    = (state_q == IDLE) && START;
  assign last_rd   = (rd_cnt == ADDR_WIDTH'(TRANS_NUM - 1));
  // rd_pipe[READ_LATENCY-1] is high when stage 1 holds the data of a real read.
  assign s2_wr     = rd_pipe[READ_LATENCY-1];
  assign last_wr   = s2_wr && (wr_cnt == CNT_WIDTH'(TRANS_NUM - 1));
  assign wr_idx    = wr_cnt[ADDR_WIDTH-1:0];
  assign do_update = (state_q == WAIT_READY) && DOWN_READY;
  assign BUSY      = (state_q != IDLE);

  assign raw_duty  = BRAM_DATA[2*WIDTH-1:WIDTH];
  assign raw_phase = BRAM_DATA[WIDTH-1:0];
  assign mod_p1    = {1'b0, mod_q} + (WIDTH+1)'(1);
  // The full-width product cannot overflow 2*WIDTH bits: (2^W-1)*2^W < 2^(2W).
  assign product   = {{WIDTH{1'b0}}, raw_duty} * {{(WIDTH-1){1'b0}}, mod_p1};

  // State register.
  // NOTE: sequential logic uses non-blocking assignments.
  // Every flop then samples pre-edge values, whatever the order of the blocks.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // The move to WAIT_READY happens on the edge of the last shadow write.
  // This lets the copy happen on the very next edge.
  always_comb begin
    // NOTE: the default comes first.
    // A path that leaves state_d unassigned would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:       if (START)      state_d = READ;
      READ:       if (last_rd)    state_d = DRAIN;
      DRAIN:      if (last_wr)    state_d = WAIT_READY;
      WAIT_READY: if (DOWN_READY) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Read side: latch MOD on acceptance, then issue one ascending address per cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mod_q     <= '0;
      rd_cnt    <= '0;
      BRAM_EN   <= 1'b0;
      BRAM_ADDR <= '0;
    end else begin
      BRAM_EN <= 1'b0;
      if (accept) begin
        mod_q  <= MOD;
        rd_cnt <= '0;
      end else if (state_q == READ) begin
        BRAM_EN   <= 1'b1;
        BRAM_ADDR <= rd_cnt;
        rd_cnt    <= rd_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Data pipeline: a read-valid delay line, the stage-1 multiply and the capture counter.
  // Stage 1 samples BRAM_DATA every edge.
  // Only samples that line up with rd_pipe are ever written.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_pipe  <= '0;
      s1_duty  <= '0;
      s1_phase <= '0;
      wr_cnt   <= '0;
    end else begin
      rd_pipe[0] <= BRAM_EN;
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      s1_duty  <= WIDTH'(product >> WIDTH);
      s1_phase <= raw_phase;
      if (accept)     wr_cnt <= '0;
      else if (s2_wr) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
    end
  end

  // Stage 2: write the scaled duty and the delayed phase into the shadow buffer.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: the shadow and front arrays are ordinary flops, not a RAM.
    // They take the asynchronous clear like any other register.
    // An aborted load therefore leaves no stale data behind.
    if (!RST_N) begin
      shadow_duty  <= '0;
      shadow_phase <= '0;
    end else if (s2_wr) begin
      shadow_duty[wr_idx]  <= s1_duty;
      shadow_phase[wr_idx] <= s1_phase;
    end
  end

  // Front buffer: copied only on the UPDATE edge.
  // OVERRUN flags a START that arrives while busy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DUTY    <= '0;
      PHASE   <= '0;
      UPDATE  <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      UPDATE  <= do_update;
      OVERRUN <= START && BUSY;
      if (do_update) begin
        DUTY  <= shadow_duty;
        PHASE <= shadow_phase;
      end
    end
  end

endmodule

// File: tb/tb_duty_phase_loader.sv
// Testbench for duty_phase_loader with TRANS_NUM=4, READ_LATENCY=2.
// Stimulus pushes the expected DUTY/PHASE arrays and the UPDATE cycle into a queue.
// A monitor pops and compares the queue on every UPDATE.
module tb_duty_phase_loader;

  localparam int TN = 4;
  localparam int W  = 8;
  localparam int RL = 2;
  localparam int AW = 2;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic                 START;
  logic [W-1:0]         MOD;
  logic                 DOWN_READY;
  logic                 BRAM_EN;
  logic [AW-1:0]        BRAM_ADDR;
  logic [2*W-1:0]       BRAM_DATA;
  logic [TN-1:0][W-1:0] DUTY;
  logic [TN-1:0][W-1:0] PHASE;
  logic                 UPDATE;
  logic                 BUSY;
  logic                 OVERRUN;

  duty_phase_loader #(
    .TRANS_NUM(TN), .WIDTH(W), .READ_LATENCY(RL), .ADDR_WIDTH(AW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .MOD(MOD), .DOWN_READY(DOWN_READY),
    .BRAM_EN(BRAM_EN), .BRAM_ADDR(BRAM_ADDR), .BRAM_DATA(BRAM_DATA),
    .DUTY(DUTY), .PHASE(PHASE), .UPDATE(UPDATE), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [TN-1:0][W-1:0] duty;
    logic [TN-1:0][W-1:0] phase;
    int                   exact;
  } exp_t;

  exp_t           sb[$];
  logic [2*W-1:0] mem [TN];
  int             cyc      = 0;
  int             n_checks = 0;
  int             n_errs   = 0;

  // cyc counts rising edges.
  always @(posedge CLK) cyc <= cyc + 1;

  // BRAM model: the address is registered at edge t and the data is registered at t+1.
  // The data is therefore stable for the DUT to sample at t+2 (READ_LATENCY=2).
  always @(posedge CLK) if (BRAM_EN) BRAM_DATA <= mem[BRAM_ADDR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: duty * (m+1) / 256, evaluated in integer arithmetic.
  function automatic logic [TN-1:0][W-1:0] exp_duty(input logic [W-1:0] m);
    logic [TN-1:0][W-1:0] r;
    for (int k = 0; k < TN; k++) begin
      int p;
      p    = int'(mem[k][15:8]) * (int'(m) + 1);
      r[k] = W'(p / 256);
    end
    return r;
  endfunction

  function automatic logic [TN-1:0][W-1:0] exp_phase();
    logic [TN-1:0][W-1:0] r;
    for (int k = 0; k < TN; k++) r[k] = mem[k][7:0];
    return r;
  endfunction

  task automatic push_exp(input logic [W-1:0] m, input int exact);
    exp_t e;
    e.duty  = exp_duty(m);
    e.phase = exp_phase();
    e.exact = exact;
    sb.push_back(e);
  endtask

  // Called at a falling edge: START is sampled at the next rising edge, e0.
  // Returns at the falling edge after e0, with START low again.
  task automatic pulse_start(input logic [W-1:0] m, output int e0);
    START = 1'b1;
    MOD   = m;
    e0    = cyc + 1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_update(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      seen = (UPDATE === 1'b1);
    end
    check("update_seen", 64'(seen), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bram_en"},   64'(BRAM_EN),   64'(0));
    check({tag, "_bram_addr"}, 64'(BRAM_ADDR), 64'(0));
    check({tag, "_update"},    64'(UPDATE),    64'(0));
    check({tag, "_busy"},      64'(BUSY),      64'(0));
    check({tag, "_overrun"},   64'(OVERRUN),   64'(0));
    check({tag, "_duty"},      64'(DUTY),      64'(0));
    check({tag, "_phase"},     64'(PHASE),     64'(0));
  endtask

  // Monitor: every UPDATE must match the oldest outstanding load.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && UPDATE === 1'b1) begin
      if (sb.size() == 0) begin
        check("update_without_load", 64'(UPDATE), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("update_duty",  64'(DUTY),  64'(e.duty));
        check("update_phase", 64'(PHASE), 64'(e.phase));
        check("update_cycle", 64'(cyc),   64'(e.exact));
      end
    end
  end

  // Watchdog in case the DUT wedges somewhere a bounded wait does not cover.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int e1;
    mem[0] = 16'hFF10;
    mem[1] = 16'h8020;
    mem[2] = 16'h4030;
    mem[3] = 16'h0040;
    RST_N = 1'b1; START = 1'b0; MOD = '0; DOWN_READY = 1'b1;
    #3 RST_N = 1'b0;
    #1 check_all_zero("reset");
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Basic load: MOD=255 leaves duty unchanged; addresses 0..3; UPDATE 8 edges after START.
    pulse_start(8'd255, e0);
    push_exp(8'd255, e0 + 8);
    check("basic_busy", 64'(BUSY), 64'(1));
    for (int i = 0; i < TN; i++) begin
      @(negedge CLK);
      check("basic_bram_en", 64'(BRAM_EN), 64'(1));
      check("basic_addr", 64'(BRAM_ADDR), 64'(i));
    end
    @(negedge CLK);
    check("basic_bram_en_off", 64'(BRAM_EN), 64'(0));
    wait_update(20);
    check("basic_busy_after_update", 64'(BUSY), 64'(0));

    // Second load with MOD=127, started on the edge right after UPDATE: accepted normally.
    pulse_start(8'd127, e0);
    push_exp(8'd127, e0 + 8);
    wait_update(20);

    // Backpressure: hold for 20 cycles after the load completes; the front arrays keep the MOD=127 result.
    DOWN_READY = 1'b0;
    pulse_start(8'd255, e0);
    push_exp(8'd255, e0 + 28);
    repeat (7) @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("bp_update_low", 64'(UPDATE), 64'(0));
      check("bp_busy", 64'(BUSY), 64'(1));
      check("bp_duty_held", 64'(DUTY), 64'(exp_duty(8'd127)));
      check("bp_phase_held", 64'(PHASE), 64'(exp_phase()));
    end
    DOWN_READY = 1'b1;
    @(negedge CLK);
    check("bp_release_update", 64'(UPDATE), 64'(1));

    // Zero modulation: duty collapses to 0, phase still passes through.
    @(negedge CLK);
    pulse_start(8'd0, e0);
    push_exp(8'd0, e0 + 8);
    wait_update(20);

    // Overrun: a START two cycles in and a START on the UPDATE edge are both rejected.
    // A START on the following edge is accepted.
    @(negedge CLK);
    pulse_start(8'd255, e0);
    push_exp(8'd255, e0 + 8);
    check("ovr_quiet0", 64'(OVERRUN), 64'(0));
    @(negedge CLK);
    check("ovr_addr0", 64'(BRAM_ADDR), 64'(0));
    START = 1'b1; MOD = 8'd0;
    @(negedge CLK);
    START = 1'b0;
    check("ovr_pulse_mid_load", 64'(OVERRUN), 64'(1));
    check("ovr_addr1", 64'(BRAM_ADDR), 64'(1));
    @(negedge CLK);
    check("ovr_pulse_one_cycle", 64'(OVERRUN), 64'(0));
    check("ovr_addr2", 64'(BRAM_ADDR), 64'(2));
    @(negedge CLK);
    check("ovr_addr3", 64'(BRAM_ADDR), 64'(3));
    repeat (3) @(negedge CLK);
    START = 1'b1; MOD = 8'd127;
    @(negedge CLK);
    check("ovr_update_edge", 64'(UPDATE), 64'(1));
    check("ovr_pulse_update_edge", 64'(OVERRUN), 64'(1));
    e1 = cyc + 1;
    push_exp(8'd127, e1 + 8);
    @(negedge CLK);
    START = 1'b0;
    check("ovr_restart_no_overrun", 64'(OVERRUN), 64'(0));
    check("ovr_restart_busy", 64'(BUSY), 64'(1));
    wait_update(20);

    // Reset mid-load while address 2 is on the bus: everything clears and no UPDATE follows.
    @(negedge CLK);
    pulse_start(8'd255, e0);
    push_exp(8'd255, e0 + 8);
    repeat (3) @(negedge CLK);
    check("rst_pre_addr", 64'(BRAM_ADDR), 64'(2));
    #2 RST_N = 1'b0;
    sb.delete();
    #1 check_all_zero("rst_mid");
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      check("rst_quiet_update", 64'(UPDATE), 64'(0));
      check("rst_quiet_busy", 64'(BUSY), 64'(0));
    end
    pulse_start(8'd127, e0);
    push_exp(8'd127, e0 + 8);
    wait_update(20);

    // Modulation stability: MOD drops to 0 one cycle after START; the load still uses 255.
    pulse_start(8'd255, e0);
    MOD = 8'd0;
    push_exp(8'd255, e0 + 8);
    wait_update(20);

    @(negedge CLK);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/duty_phase_loader.md
Name: duty_phase_loader

Overview:
- Upstream feeder of the silent LPF stage.
- On each START it streams TRANS_NUM duty/phase words out of the operation BRAM and applies an 8-bit amplitude modulation to duty.
- It double-buffers the result and presents a stable DUTY/PHASE array set with a one-cycle UPDATE pulse, but only when the downstream stage reports it is ready.
- It sits between the BRAM controller and the LPF, which samples DUTY/PHASE on UPDATE.

Parameters:
- TRANS_NUM, 249, number of transducers; one BRAM word each.
- WIDTH, 8, duty/phase width. BRAM word is 2*WIDTH, duty in [2*WIDTH-1:WIDTH], phase in [WIDTH-1:0].
- READ_LATENCY, 2, edges from address registered to BRAM_DATA valid (≥1).
- ADDR_WIDTH, $clog2(TRANS_NUM), BRAM address width.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle load request.
- MOD  in  WIDTH  modulation amplitude; sampled on the accepted START.
- DOWN_READY  in  1  downstream idle; UPDATE is issued only while high.
- BRAM_EN  out  1  BRAM read enable.
- BRAM_ADDR  out  ADDR_WIDTH  BRAM read address.
- BRAM_DATA  in  2*WIDTH  BRAM read data.
- DUTY  out  WIDTH x TRANS_NUM  modulated duty array (registered, front buffer).
- PHASE  out  WIDTH x TRANS_NUM  phase array (registered, front buffer).
- UPDATE  out  1  one-cycle pulse; arrays are new in the same cycle.
- BUSY  out  1  high whenever state != IDLE.
- OVERRUN  out  1  one-cycle pulse when START is rejected.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE.
  - BRAM_EN, BRAM_ADDR, UPDATE, BUSY, OVERRUN all 0.
  - DUTY, PHASE and shadow arrays all 0.
  - All counters and the MOD register cleared.
  - Reset mid-load aborts the load; no UPDATE follows, and front arrays are 0 after reset.
- States: IDLE, READ, DRAIN, WAIT_READY.
- IDLE:
  - START=1 at edge e0 latches mod_q=MOD, clears counters, moves to READ.
- READ:
  - At edges e0+1 .. e0+TRANS_NUM, drive BRAM_EN=1 with BRAM_ADDR=0..TRANS_NUM-1, one address per cycle, ascending.
  - After the address TRANS_NUM-1 edge, BRAM_EN=0 and state=DRAIN.
- Data path:
  - Data for the address registered at edge t is sampled at edge t+READ_LATENCY.
  - Stage 1 at that edge computes prod = raw_duty * (mod_q+1), an unsigned WIDTH x (WIDTH+1) multiply with no saturation needed.
  - Stage 2 on the next edge writes shadow_duty[k] = prod[2*WIDTH-1:WIDTH] and shadow_phase[k] = raw_phase (delayed to match).
  - A capture counter k advances on each stage-2 write.
- Modulation boundaries:
  - mod_q=255 gives duty unchanged.
  - mod_q=0 gives duty = raw>>WIDTH, i.e. 0 for WIDTH=8.
  - The result is never greater than raw_duty.
- DRAIN:
  - When k reaches TRANS_NUM (last write at edge e0+TRANS_NUM+READ_LATENCY+1), move to WAIT_READY.
- WAIT_READY:
  - On the first edge where DOWN_READY=1, copy shadow→DUTY/PHASE, drive UPDATE=1 for exactly that cycle, return to IDLE.
  - Minimum START→UPDATE latency is TRANS_NUM+READ_LATENCY+2 edges.
  - While DOWN_READY=0, hold indefinitely; front arrays and UPDATE stay unchanged.
- Front arrays change only on the UPDATE edge or on reset, never during a load.
- START while BUSY, including the UPDATE edge itself: ignored, OVERRUN=1 for one cycle, load in progress unaffected, mod_q unchanged.
- START on the edge after UPDATE (state IDLE): accepted normally.
- MOD changes after acceptance have no effect on the current load.

Test Plan:
- Basic load (TRANS_NUM=4, READ_LATENCY=2). Setup: BRAM words {0xFF10,0x8020,0x4030,0x0040}, MOD=255, DOWN_READY=1, START pulse. Expected: BRAM_ADDR 0,1,2,3 on consecutive cycles; UPDATE exactly 8 edges after START; DUTY={255,128,64,0}; PHASE={0x10,0x20,0x30,0x40}; BUSY low after UPDATE.
- Modulation scaling. Setup: same data, MOD=127. Expected: DUTY={127,64,32,0}. With MOD=0: DUTY={0,0,0,0}, PHASE unchanged.
- Backpressure. Setup: DOWN_READY=0 for 20 cycles after load completes. Expected: UPDATE stays 0, DUTY/PHASE keep previous values, BUSY=1. Raising DOWN_READY gives UPDATE on the next edge with the new arrays.
- Overrun. Setup: second START 2 cycles after the first, and another START on the UPDATE cycle. Expected: OVERRUN pulses both times, exactly one UPDATE, addresses not restarted; a START one cycle after UPDATE is accepted.
- Reset mid-load. Setup: assert RST_N=0 asynchronously while BRAM_ADDR=2. Expected: all outputs 0 immediately, no UPDATE afterwards; a following START completes a clean load.
- MOD stability. Setup: change MOD from 255 to 0 one cycle after START. Expected: result uses 255 (DUTY equals raw duty).
